par2ser_gearbox: RTL
====================

Name: par2ser_gearbox

Overview:
- Parametrised, multi-channel fabric parallel-to-serial gearbox.
- Slices DIN_W-bit words into DOUT_W-bit chunks, one chunk per clock.
- Next generation of the fixed 10:1 HDMI serializer path: configurable width, ratio, channel count and bit order, with valid/ready input, idle-word insertion on underflow, and a training-pattern mode.
- Sits between the TMDS encoders and the DDR output primitives or pins.

Parameters:
- CH, 3, number of lock-stepped channels.
- DIN_W, 10, input word width per channel.
- DOUT_W, 2, output slice width per channel. DIN_W must be an integer multiple of DOUT_W, and RATIO = DIN_W/DOUT_W must be at least 2.
- MSB_FIRST, 0, 0 emits the LSB slice first; 1 emits the MSB slice first.
- IDLE_WORD, 10'b1101010100, word inserted on every channel on underflow.
- UFL_W, 16, width of the saturating underflow counter.

Ports:
- clkx1, in, 1, single clock; all logic runs on it.
- rst, in, 1, asynchronous active-high reset.
- din_valid, in, 1, input words present.
- din_ready, out, 1, word slot open this cycle.
- din, in, CH*DIN_W, channel k occupies bits [k*DIN_W +: DIN_W].
- train_en, in, 1, when high, load train_word instead of din.
- train_word, in, DIN_W, pattern driven on all channels during training.
- dout, out, CH*DOUT_W, current slice; channel k occupies bits [k*DOUT_W +: DOUT_W].
- dout_valid, out, 1, high once the first word has been loaded.
- word_start, out, 1, high on the cycle dout carries the first slice of a word.
- underflow, out, 1, one-cycle pulse when IDLE_WORD is inserted.
- ufl_cnt, out, UFL_W, saturating count of underflow events.

Behaviour:
- Reset is asynchronous, active-high. While rst is high:
  - shift registers = 0, so dout = 0
  - slice counter cnt = RATIO-1
  - dout_valid = 0, word_start = 0, underflow = 0, ufl_cnt = 0
  - din_ready = 0 (din_ready is gated by !rst)
- din_ready = !rst && (cnt == RATIO-1) && !train_en. It is combinational from registers only; it has no path from din_valid.
- Every clkx1 edge:
  - If cnt == RATIO-1: load cnt <= 0 and set dout_valid <= 1. The per-channel shift registers load by priority:
    1. train_en = 1: train_word on all channels.
    2. din_valid = 1: din (accepted).
    3. Otherwise: IDLE_WORD on all channels.
  - Else: cnt <= cnt+1, and each shift register shifts by DOUT_W (right when MSB_FIRST=0, left when MSB_FIRST=1).
- dout is a register-sourced slice: the low DOUT_W bits (MSB_FIRST=0) or the high DOUT_W bits (MSB_FIRST=1) of each shift register.
- word_start is registered and equals (cnt == 0) after the edge.
- Latency: a word accepted at edge t appears as its first slice from t+1 and its last slice at t+RATIO. The next acceptance is at t+RATIO. Back-to-back words produce a continuous stream with no gaps.
- Underflow:
  - Only counted when an IDLE_WORD load occurs with dout_valid already 1. The first load after reset never flags underflow.
  - underflow is high for the single cycle of the idle word's first slice.
  - ufl_cnt increments on the same edge and saturates at 2^UFL_W-1.
- Training:
  - train_en is sampled only at load edges; a toggle mid-word does not affect the word in flight.
  - During training: no input is consumed, underflow is not raised, and ufl_cnt does not change.
- Multi-channel: all channels share cnt, so slices stay bit-aligned across channels.
- Reset mid-word: the word in flight is discarded immediately. The first load happens on the first edge after rst deasserts.
- Width rules: shifts fill vacated bits with 0. Bit order on dout within a slice is {hi,lo}, unchanged by MSB_FIRST.

Test Plan:
1. Basic LSB-first: CH=1, DIN_W=10, DOUT_W=2, din=10'b1100110101 held valid -> dout = 01,01,11,00,11 repeating. word_start and din_ready are high once every 5 cycles. No underflow.
2. Underflow: drop din_valid for one slot -> dout = 00,01,01,01,11 (IDLE_WORD). underflow is high on the 00 cycle only; ufl_cnt 0->1. Data resumes at the next slot.
3. Training: train_en=1, train_word=10'h3FF, din_valid=1 -> din_ready=0, dout=11 every cycle, underflow=0, ufl_cnt unchanged. The held din word is emitted first after train_en drops.
4. MSB-first: MSB_FIRST=1, din=10'b1100110101 -> dout = 11,00,11,01,01.
5. Reset mid-word: assert rst at the third slice -> dout=0, dout_valid=0, din_ready=0 immediately. After release, a load occurs on the first edge and there is no underflow pulse even if din_valid=0.
6. Multi-channel and saturation: CH=3, distinct words 10'h155/10'h2AA/10'h0F0 -> per-channel slices aligned with a single word_start. With UFL_W=2, repeated starvation drives ufl_cnt to 3 and holds it there.

Source files
------------

// File: rtl/par2ser_gearbox_if.sv
// Parallel-to-serial gearbox bus: word input handshake
// plus the sliced output stream and underflow status.
interface par2ser_gearbox_if #(
  parameter int CH     = 3,
  parameter int DIN_W  = 10,
  parameter int DOUT_W = 2,
  parameter int UFL_W  = 16
);
  logic                 din_valid;
  logic                 din_ready;
  logic [CH*DIN_W-1:0]  din;
  logic                 train_en;
  logic [DIN_W-1:0]     train_word;
  logic [CH*DOUT_W-1:0] dout;
  logic                 dout_valid;
  logic                 word_start;
  logic                 underflow;
  logic [UFL_W-1:0]     ufl_cnt;

  modport master (
    output din_valid, din, train_en, train_word,
    input  din_ready, dout, dout_valid,
    input  word_start, underflow, ufl_cnt
  );

  modport slave (
    input  din_valid, din, train_en, train_word,
    output din_ready, dout, dout_valid,
    output word_start, underflow, ufl_cnt
  );
endinterface

// File: rtl/par2ser_gearbox.sv
// Multi-channel parallel-to-serial gearbox: DIN_W words
// sliced into DOUT_W chunks, one chunk per clkx1 cycle.
module par2ser_gearbox #(
  parameter int               CH        = 3,
  parameter int               DIN_W     = 10,
  parameter int               DOUT_W    = 2,
  parameter int               MSB_FIRST = 0,
  parameter logic [DIN_W-1:0] IDLE_WORD = 10'b1101010100,
  parameter int               UFL_W     = 16
) (
  input logic              clkx1,
  input logic              rst,
  par2ser_gearbox_if.slave bus
);
  localparam int RATIO = DIN_W / DOUT_W;
  localparam int CW    = $clog2(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [CW-1:0]       cnt;
  logic [DIN_W-1:0]    sr  [CH];
  logic [DIN_W-1:0]    nxt [CH];
  logic [CH*DOUT_W-1:0] dout_w;
  logic                load;
  logic                idle_ld;
  logic                dv_q;
  logic                ws_q;
  logic                ufl_q;
  logic [UFL_W-1:0]    ufl_cnt_q;

  assign load    = (cnt == LAST);
  assign idle_ld = load && !bus.train_en && !bus.din_valid;

  assign bus.din_ready  = !rst && load && !bus.train_en;
  assign bus.dout       = dout_w;
  assign bus.dout_valid = dv_q;
  assign bus.word_start = ws_q;
  assign bus.underflow  = ufl_q;
  assign bus.ufl_cnt    = ufl_cnt_q;

  // training overrides data, data overrides idle fill
  always_comb begin
    for (int k = 0; k < CH; k++) nxt[k] = IDLE_WORD;
    unique case (1'b1)
      bus.train_en: begin
        for (int k = 0; k < CH; k++)
          nxt[k] = bus.train_word;
      end
      (!bus.train_en && bus.din_valid): begin
        for (int k = 0; k < CH; k++)
          nxt[k] = bus.din[k*DIN_W +: DIN_W];
      end
      default: begin
        for (int k = 0; k < CH; k++)
          nxt[k] = IDLE_WORD;
      end
    endcase
  end

  always_comb begin
    dout_w = '0;
    for (int k = 0; k < CH; k++) begin
      if (MSB_FIRST != 0)
        dout_w[k*DOUT_W +: DOUT_W] = sr[k][DIN_W-1 -: DOUT_W];
      else
        dout_w[k*DOUT_W +: DOUT_W] = sr[k][DOUT_W-1:0];
    end
  end

  always_ff @(posedge clkx1 or posedge rst) begin
    if (rst) begin
      cnt <= LAST;
      for (int k = 0; k < CH; k++) sr[k] <= '0;
    end else if (load) begin
      cnt <= '0;
      for (int k = 0; k < CH; k++) sr[k] <= nxt[k];
    end else begin
      cnt <= cnt + 1'b1;
      for (int k = 0; k < CH; k++) begin
        if (MSB_FIRST != 0) sr[k] <= sr[k] << DOUT_W;
        else                sr[k] <= sr[k] >> DOUT_W;
      end
    end
  end

  // the very first load after reset is not a starvation event
  always_ff @(posedge clkx1 or posedge rst) begin
    if (rst) begin
      dv_q      <= 1'b0;
      ws_q      <= 1'b0;
      ufl_q     <= 1'b0;
      ufl_cnt_q <= '0;
    end else begin
      ws_q  <= load;
      ufl_q <= idle_ld && dv_q;
      if (load) dv_q <= 1'b1;
      if (idle_ld && dv_q && (ufl_cnt_q != '1))
        ufl_cnt_q <= ufl_cnt_q + 1'b1;
    end
  end
endmodule
